fnd_display_ctrl: RTL

Downstream consumer of the 14-bit 0–9999 count value; drives a 4-digit common-anode 7-segment (FND) display. Converts the binary value to four BCD digits with a sequential shift-add-3 (double-dabble) engine, latches the result into a display register, and time-multiplexes the digits onto shared segment lines. Sits between the counter stage and the board FND pins.

---
 rtl/fnd_pkg.sv | 53 +++++
 rtl/bin2bcd_seq.sv | 69 ++++++
 rtl/fnd_display_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, converter state encoding and segment decode for the FND display controller.
package fnd_pkg;

  localparam int unsigned BIN_W   = 14;
  localparam int unsigned BCD_W   = 16;
  localparam int unsigned MAX_VAL = 9999;
  localparam int unsigned SHIFT_N = BIN_W;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is kept off in every pattern
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] COM_OFF   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Double-dabble correction applied to one BCD nibble before each shift
  function automatic logic [3:0] bcd_adj(input logic [3:0] nib);
    return (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: LOAD, 14 SHIFT cycles, DONE.
module bin2bcd_seq
  import fnd_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              start,
  input  logic [BIN_W-1:0]  bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output conv_state_t       state
);

  localparam int unsigned CNT_W = $clog2(SHIFT_N);

  conv_state_t      state_nx;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] sh_bin;
  logic [BCD_W-1:0] adj_c;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  state_nx = ST_SHIFT;
      ST_SHIFT: if (cnt == CNT_W'(SHIFT_N - 1)) state_nx = ST_DONE;
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    adj_c = '0;
    for (int k = 0; k < 4; k++) adj_c[4*k +: 4] = bcd_adj(bcd[4*k +: 4]);
  end

  // Datapath; busy/done are registered from the next state so they align with it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      cnt    <= '0;
      sh_bin <= '0;
      bcd    <= '0;
    end else begin
      busy <= (state_nx == ST_LOAD) || (state_nx == ST_SHIFT);
      done <= (state_nx == ST_DONE);
      case (state)
        ST_LOAD: begin
          sh_bin <= (bin > BIN_W'(MAX_VAL)) ? BIN_W'(MAX_VAL) : bin;
          bcd    <= '0;
          cnt    <= '0;
        end
        ST_SHIFT: begin
          {bcd, sh_bin} <= {adj_c[BCD_W-2:0], sh_bin, 1'b0};
          cnt           <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fnd_display_ctrl.sv
// 4-digit common-anode FND driver: change-triggered BCD conversion plus digit scan.
// Define FND_ZERO_BLANK_EN to blank leading zeros (ones digit always shown).
module fnd_display_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100_000
)(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [BIN_W-1:0] i_value,
  output logic [7:0]       o_seg,
  output logic [3:0]       o_com,
  output logic             o_busy
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [BIN_W-1:0] r_last;
  logic             r_first;
  logic [BCD_W-1:0] r_disp;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_idx;

  conv_state_t      conv_state;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             start_c;
  logic [7:0]       seg_c;

  // Raw value comparison so out-of-range changes still retrigger a conversion
  assign start_c = (conv_state == ST_IDLE) && (r_first || (i_value != r_last));

  bin2bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .start   (start_c),
    .bin     (i_value),
    .busy    (o_busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .state   (conv_state)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_last  <= '0;
      r_first <= 1'b1;
      r_disp  <= '0;
    end else begin
      if (conv_state == ST_LOAD) r_last <= i_value;
      if (conv_done) begin
        r_disp  <= conv_bcd;
        r_first <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  always_comb begin
    seg_c = seg_decode(r_disp[{r_idx, 2'b00} +: 4]);
`ifdef FND_ZERO_BLANK_EN
    // Digit is a leading zero when it and every higher nibble are zero
    if ((r_idx != 2'd0) && ((r_disp >> {r_idx, 2'b00}) == '0)) seg_c = SEG_BLANK;
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_seg <= SEG_BLANK;
      o_com <= COM_OFF;
    end else begin
      o_seg <= seg_c;
      o_com <= ~(4'b0001 << r_idx);
    end
  end

endmodule
